// File: rtl/user_mem_io_pkg.sv
// Shared offsets, control-bit indices and timer state type
// for the user-memory responder.
package user_mem_io_pkg;

  localparam logic [7:0] OFF_GPIO_OUT   = 8'd0;
  localparam logic [7:0] OFF_GPIO_IN    = 8'd1;
  localparam logic [7:0] OFF_TMR_RELOAD = 8'd2;
  localparam logic [7:0] OFF_TMR_CTRL   = 8'd3;
  localparam logic [7:0] OFF_TMR_COUNT  = 8'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 7;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/user_mem_timer.sv
// Down-counting reload timer with prescaler, W1C pending flag
// and registered level interrupt.
import user_mem_io_pkg::*;

module user_mem_timer #(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_reload,
  input  logic       wr_ctrl,
  input  logic [7:0] wdata,
  output logic [7:0] reload,
  output logic [7:0] ctrl,
  output logic [7:0] count,
  output logic       interrupt
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  tmr_state_e  state, state_n;
  logic [15:0] presc, presc_n;
  logic [7:0]  count_n, reload_n;
  logic        ie, ie_n, pend, pend_n;
  logic        start, stop, tick;

  always_comb begin
    state_n  = state;
    presc_n  = presc;
    count_n  = count;
    reload_n = reload;
    ie_n     = ie;
    pend_n   = pend;
    start    = wr_ctrl && wdata[CTRL_EN] && (state == T_IDLE);
    stop     = wr_ctrl && !wdata[CTRL_EN];
    tick     = (state == T_RUN) && !stop && (presc == PS_LAST);
    if (wr_reload) reload_n = wdata;
    if (wr_ctrl) begin
      ie_n    = wdata[CTRL_IE];
      state_n = wdata[CTRL_EN] ? T_RUN : T_IDLE;
      if (wdata[CTRL_PEND]) pend_n = 1'b0;
    end
    if (start) begin
      count_n = reload;
      presc_n = '0;
    end else if (state == T_RUN && !stop) begin
      presc_n = (presc == PS_LAST) ? '0 : presc + 16'd1;
    end
    // a reload tick overrides a same-edge W1C clear
    if (tick) begin
      if (count == 8'd0) begin
        count_n = reload;
        pend_n  = 1'b1;
      end else begin
        count_n = count - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= T_IDLE;
      presc     <= '0;
      count     <= '0;
      reload    <= '0;
      ie        <= 1'b0;
      pend      <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      count     <= count_n;
      reload    <= reload_n;
      ie        <= ie_n;
      pend      <= pend_n;
      interrupt <= pend & ie;
    end
  end

  assign ctrl = {pend, 5'b0, ie, state == T_RUN};

endmodule

// File: rtl/user_mem_io.sv
// Data-side byte RAM plus GPIO/timer I/O window for the 8-bit core.
// Timer is built only when USER_MEM_IO_TIMER_EN is defined.
import user_mem_io_pkg::*;

module user_mem_io #(
  parameter int         RAM_DEPTH = 240,
  parameter logic [7:0] IO_BASE   = 8'hF0,
  parameter int         PRESCALE  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rw,
  input  logic [7:0] usermem_address,
  input  logic [7:0] usermem_data,
  output logic [7:0] usermem_rdata,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       interrupt
);

  localparam logic [8:0] RAM_END = 9'(RAM_DEPTH);

  if (PRESCALE < 1 || RAM_DEPTH > int'(IO_BASE)) begin : g_bad_cfg
    $error("user_mem_io: bad PRESCALE or RAM_DEPTH");
  end

  logic [7:0] mem [RAM_DEPTH];
  logic [7:0] io_rel, rdata_n;
  logic [7:0] gpio_s1, gpio_s2;
  logic       is_ram, is_io;

  assign io_rel = usermem_address - IO_BASE;
  assign is_ram = {1'b0, usermem_address} < RAM_END;
  assign is_io  = (usermem_address >= IO_BASE) && (io_rel < 8'd16);

  always_ff @(posedge clk) begin
    if (rw && is_ram && !reset) mem[usermem_address] <= usermem_data;
  end

`ifdef USER_MEM_IO_TIMER_EN
  logic [7:0] tmr_reload, tmr_ctrl, tmr_count;

  user_mem_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_reload (rw && is_io && io_rel == OFF_TMR_RELOAD),
    .wr_ctrl   (rw && is_io && io_rel == OFF_TMR_CTRL),
    .wdata     (usermem_data),
    .reload    (tmr_reload),
    .ctrl      (tmr_ctrl),
    .count     (tmr_count),
    .interrupt (interrupt)
  );
`else
  assign interrupt = 1'b0;
`endif

  always_comb begin
    rdata_n = '0;
    if (is_ram) begin
      rdata_n = mem[usermem_address];
    end else if (is_io) begin
      case (io_rel)
        OFF_GPIO_OUT:   rdata_n = gpio_out;
        OFF_GPIO_IN:    rdata_n = gpio_s2;
`ifdef USER_MEM_IO_TIMER_EN
        OFF_TMR_RELOAD: rdata_n = tmr_reload;
        OFF_TMR_CTRL:   rdata_n = tmr_ctrl;
        OFF_TMR_COUNT:  rdata_n = tmr_count;
`endif
        default:        rdata_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      usermem_rdata <= '0;
      gpio_out      <= '0;
      gpio_s1       <= '0;
      gpio_s2       <= '0;
    end else begin
      usermem_rdata <= rdata_n;
      gpio_s1       <= gpio_in;
      gpio_s2       <= gpio_s1;
      if (rw && is_io && io_rel == OFF_GPIO_OUT) gpio_out <= usermem_data;
    end
  end

endmodule

// File: doc/user_mem_io.md
Name: user_mem_io

Overview:
- Responder for the CPU control unit's user-memory interface. It services the control unit's `rw`, `usermem_address` and `usermem_data` (write) with a byte RAM, and returns read data with registered 1-cycle latency.
- Decodes a small memory-mapped I/O window with three functions: a GPIO output register, a synchronized GPIO input, and a down-counting timer.
- The timer drives the control unit's `interrupt` input.
- Sits beside the control unit and PC as the data-side memory of the 8-bit core.

Parameters:
- RAM_DEPTH, 240, number of RAM bytes mapped from 0x00 upward; must be <= IO_BASE.
- IO_BASE, 8'hF0, first address of the I/O window, which is 16 bytes (IO_BASE..IO_BASE+15).
- PRESCALE, 1, clock cycles per timer tick; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rw  in  1  1 = write `usermem_data` to `usermem_address` at this edge; 0 = read.
- usermem_address  in  8  byte address.
- usermem_data  in  8  write data from the control unit.
- usermem_rdata  out  8  registered read data.
- gpio_in  in  8  asynchronous external inputs.
- gpio_out  out  8  GPIO output register.
- interrupt  out  1  level interrupt request to the control unit.

Behaviour:
- Reset:
  - `usermem_rdata`, `gpio_out`, `interrupt`, the GPIO sync flops and all timer registers clear to 0, and the prescaler restarts.
  - RAM contents are not reset.
  - Reset mid-access aborts the access; no partial write occurs.
- Address map:
  - 0x00..RAM_DEPTH-1: RAM.
  - IO_BASE+0: GPIO_OUT, read/write.
  - IO_BASE+1: GPIO_IN, read-only, 2-flop synchronized.
  - IO_BASE+2: TMR_RELOAD, read/write.
  - IO_BASE+3: TMR_CTRL, with fields:
    - bit0 EN, read/write.
    - bit1 IE, read/write.
    - bit7 PEND: reads the pending flag; writing 1 clears it, writing 0 has no effect.
    - other bits read 0.
  - IO_BASE+4: TMR_COUNT, read-only.
  - Any other address reads 0x00 and ignores writes.
- Write: when `rw`=1 at a rising edge, the target is updated at that edge. Repeated writes across consecutive cycles are harmless (idempotent).
- Read:
  - `usermem_rdata` is registered every cycle regardless of `rw`. After edge n it holds the contents of the address presented at edge n.
  - Read-during-write to the same address returns the old value (read-first).
- GPIO_IN read latency is 2 sync cycles plus 1 read cycle.
- Timer:
  - States: IDLE (EN=0) and RUN (EN=1).
  - IDLE -> RUN: a TMR_CTRL write with EN=1 while EN was 0 loads COUNT <= RELOAD and resets the prescaler.
  - In RUN, on each tick (every PRESCALE cycles):
    - If COUNT==0: COUNT <= RELOAD and PEND <= 1.
    - Otherwise COUNT <= COUNT-1.
  - With RELOAD=0, PEND sets on every tick.
  - RUN -> IDLE: a write with EN=0 freezes COUNT; PEND is kept.
  - Arithmetic is 8-bit unsigned; COUNT never wraps below 0.
  - A write to TMR_RELOAD does not affect COUNT until the next reload.
- Interrupt:
  - `interrupt` = PEND & IE, registered, so it asserts 1 cycle after PEND sets.
  - It is held until cleared by a W1C write or IE=0.
- Simultaneous events: if a PEND set and a W1C clear land on the same edge, the set wins and PEND stays 1.

Optional Feature:
- Macro: USER_MEM_IO_TIMER_EN.
- Defined: the timer is present as described above.
- Undefined:
  - No timer logic is built.
  - IO_BASE+2..+4 read 0x00 and ignore writes.
  - `interrupt` is tied to 0.
  - RAM and GPIO are unchanged.

Decomposition:
- Shared package `user_mem_io_pkg` holds:
  - the I/O register offsets: OFF_GPIO_OUT=0, OFF_GPIO_IN=1, OFF_TMR_RELOAD=2, OFF_TMR_CTRL=3, OFF_TMR_COUNT=4;
  - the TMR_CTRL bit indices: EN=0, IE=1, PEND=7.
- One sub-module, `user_mem_timer`, containing the prescaler, COUNT, RELOAD, CTRL and interrupt register. It is instantiated only under USER_MEM_IO_TIMER_EN.
- RAM, address decode and the read mux stay in the top level.

Test Plan:
- RAM write then read:
  - Stimulus: rw=1, addr 0x10, data 0xA5 for 1 cycle; then rw=0, addr 0x10.
  - Response: `usermem_rdata`=0xA5 one cycle later. Reading addr 0xEF afterwards returns its last written value.
- Read-first collision and unmapped address:
  - Stimulus: write 0x3C to 0x20, then write 0x7E to 0x20 with the same-cycle read.
  - Response: rdata=0x3C; the next cycle reads 0x7E. A read of IO_BASE+9 returns 0x00, and a write there changes nothing.
- GPIO:
  - Stimulus: write 0x5A to IO_BASE+0; separately drive `gpio_in`=0xC3 and read IO_BASE+1.
  - Response: `gpio_out`=0x5A after the edge. The read returns 0xC3 no later than 3 cycles after the input change.
- Timer and interrupt (PRESCALE=1):
  - Stimulus: RELOAD=3; CTRL=0x03.
  - Response: COUNT goes 3,2,1,0 over the cycles after enable; PEND sets on the next tick as COUNT reloads to 3; `interrupt`=1 one cycle later.
  - Stimulus: write CTRL=0x83.
  - Response: `interrupt` drops; periodic re-assertion occurs every 4 ticks.
- Set-wins collision and reset:
  - Stimulus: a W1C write lands on the reload tick.
  - Response: PEND stays 1.
  - Stimulus: assert `reset` asynchronously mid-count.
  - Response: `interrupt`, `gpio_out`, `usermem_rdata` and COUNT go to 0 immediately.
- Macro off (USER_MEM_IO_TIMER_EN undefined):
  - Stimulus: write CTRL=0x03, RELOAD=0.
  - Response: reads of IO_BASE+2..+4 return 0x00 and `interrupt` stays 0 for 100 cycles.
